undo_stack: RTL and testbench

- Parametrised circular undo buffer for the reversible AXA pipeline; successor to the fixed 16-entry, 16-bit inline undo array.
- Adds occupancy tracking, registered pop/peek ports, commit (the `com` discard), and sticky overflow/underflow flags.
- Sits beside the register-read stage:
  - forward-mode push ops and `land` push here;
  - reverse-mode restores pop;
  - `@u` (ILTypeUnd) sources peek by offset.

---
 rtl/undo_stack.sv | 211 +++++++++++++++++++++
 tb/tb_undo_stack.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/undo_stack.sv
// Circular undo buffer: push/pop/peek with occupancy, commit discard and sticky lost/underflow flags.
// Optional per-entry even parity with a sticky parity_err output when UNDO_STACK_PARITY_EN is defined.
module undo_stack #(
  parameter int WIDTH      = 16,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      pop_data,
  output logic                  pop_valid,
  input  logic                  peek_en,
  input  logic [DEPTH_LOG2-1:0] peek_off,
  output logic [WIDTH-1:0]      peek_data,
  output logic                  peek_valid,
  input  logic                  commit,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  lost,
  output logic                  underflow
`ifdef UNDO_STACK_PARITY_EN
  ,
  output logic                  parity_err
`endif
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
`ifdef UNDO_STACK_PARITY_EN
  localparam int EW = WIDTH + 1;
`else
  localparam int EW = WIDTH;
`endif
  localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_ZERO  = (DEPTH_LOG2+1)'(0);
  localparam logic [DEPTH_LOG2:0]   CNT_DEPTH = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);

  // Stored entry format: data, with the even-parity bit on top when enabled.
  function automatic logic [EW-1:0] encode_entry(input logic [WIDTH-1:0] d);
`ifdef UNDO_STACK_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

`ifdef UNDO_STACK_PARITY_EN
  function automatic logic entry_parity_bad(input logic [EW-1:0] e);
    return ^e;
  endfunction
`endif

  logic [EW-1:0]         mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] sp_q, sp_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [WIDTH-1:0]      pop_data_q, pop_data_d;
  logic [WIDTH-1:0]      peek_data_q, peek_data_d;
  logic                  pop_valid_q, pop_valid_d;
  logic                  peek_valid_q, peek_valid_d;
  logic                  lost_q, lost_d;
  logic                  underflow_q, underflow_d;

  logic                  empty_s, full_s, pop_ok_s;
  logic [DEPTH_LOG2-1:0] top_idx_s, peek_idx_s;
  logic [EW-1:0]         top_entry_s, peek_entry_s;
  logic                  mem_we_s;
  logic [DEPTH_LOG2-1:0] mem_waddr_s;
  logic [EW-1:0]         mem_wdata_s;

  assign empty_s      = (count_q == CNT_ZERO);
  assign full_s       = (count_q == CNT_DEPTH);
  assign pop_ok_s     = pop && !commit && !empty_s;
  assign top_idx_s    = sp_q - PTR_ONE;
  assign peek_idx_s   = top_idx_s - peek_off;
  assign top_entry_s  = mem_q[top_idx_s];
  assign peek_entry_s = mem_q[peek_idx_s];

  // Next-state: commit dominates, then legal pop (with optional replace-top), then push/underflow.
  always_comb begin
    sp_d         = sp_q;
    count_d      = count_q;
    pop_data_d   = pop_data_q;
    pop_valid_d  = 1'b0;
    peek_data_d  = peek_data_q;
    peek_valid_d = 1'b0;
    lost_d       = lost_q;
    underflow_d  = underflow_q;
    mem_we_s     = 1'b0;
    mem_waddr_s  = sp_q;
    mem_wdata_s  = encode_entry(push_data);

    if (commit) begin
      lost_d = 1'b0;
      if (push) begin
        mem_we_s = 1'b1;
        sp_d     = sp_q + PTR_ONE;
        count_d  = CNT_ONE;
      end else begin
        count_d  = CNT_ZERO;
      end
    end else if (pop_ok_s) begin
      pop_data_d  = top_entry_s[WIDTH-1:0];
      pop_valid_d = 1'b1;
      if (push) begin
        mem_we_s    = 1'b1;
        mem_waddr_s = top_idx_s;
      end else begin
        sp_d    = top_idx_s;
        count_d = count_q - CNT_ONE;
      end
    end else begin
      if (pop) begin
        underflow_d = 1'b1;
      end else begin
        underflow_d = underflow_q;
      end
      if (push) begin
        mem_we_s = 1'b1;
        sp_d     = sp_q + PTR_ONE;
        if (full_s) begin
          lost_d = 1'b1;
        end else begin
          count_d = count_q + CNT_ONE;
        end
      end else begin
        sp_d = sp_q;
      end
    end

    // Peek sees the state before this cycle's push/pop.
    if (peek_en) begin
      peek_data_d  = peek_entry_s[WIDTH-1:0];
      peek_valid_d = ({1'b0, peek_off} < count_q);
    end else begin
      peek_data_d  = peek_data_q;
      peek_valid_d = 1'b0;
    end
  end

  // Entry storage; not cleared by reset, and reset blocks writes.
  always_ff @(posedge clk) begin
    if (mem_we_s && !reset) begin
      mem_q[mem_waddr_s] <= mem_wdata_s;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q         <= {DEPTH_LOG2{1'b0}};
      count_q      <= CNT_ZERO;
      pop_data_q   <= {WIDTH{1'b0}};
      pop_valid_q  <= 1'b0;
      peek_data_q  <= {WIDTH{1'b0}};
      peek_valid_q <= 1'b0;
      lost_q       <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      sp_q         <= sp_d;
      count_q      <= count_d;
      pop_data_q   <= pop_data_d;
      pop_valid_q  <= pop_valid_d;
      peek_data_q  <= peek_data_d;
      peek_valid_q <= peek_valid_d;
      lost_q       <= lost_d;
      underflow_q  <= underflow_d;
    end
  end

`ifdef UNDO_STACK_PARITY_EN
  logic parity_err_q, parity_err_d;

  // Sticky parity error, checked only on entries that are actually occupied.
  always_comb begin
    parity_err_d = parity_err_q;
    if (commit) begin
      parity_err_d = 1'b0;
    end else if ((pop_ok_s && entry_parity_bad(top_entry_s)) ||
                 (peek_en && ({1'b0, peek_off} < count_q) && entry_parity_bad(peek_entry_s))) begin
      parity_err_d = 1'b1;
    end else begin
      parity_err_d = parity_err_q;
    end
  end

  // Parity error register.
  always_ff @(posedge clk) begin
    if (reset) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= parity_err_d;
    end
  end

  assign parity_err = parity_err_q;
`endif

  assign pop_data   = pop_data_q;
  assign pop_valid  = pop_valid_q;
  assign peek_data  = peek_data_q;
  assign peek_valid = peek_valid_q;
  assign count      = count_q;
  assign empty      = empty_s;
  assign full       = full_s;
  assign lost       = lost_q;
  assign underflow  = underflow_q;

endmodule

// File: tb/tb_undo_stack.sv
// Self-checking bench for undo_stack: directed scenarios then randomized traffic against a queue-based model.
module tb_undo_stack;
  localparam int W  = 16;
  localparam int DL = 4;
  localparam int D  = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          push, pop, peek_en, commit;
  logic [W-1:0]  push_data;
  logic [DL-1:0] peek_off;
  logic [W-1:0]  pop_data, peek_data;
  logic          pop_valid, peek_valid, empty, full, lost, underflow;
  logic [DL:0]   count;
`ifdef UNDO_STACK_PARITY_EN
  logic          parity_err;
`endif

  always #5 clk = ~clk;

  undo_stack #(.WIDTH(W), .DEPTH_LOG2(DL)) dut (
    .clk(clk), .reset(reset), .push(push), .push_data(push_data), .pop(pop),
    .pop_data(pop_data), .pop_valid(pop_valid), .peek_en(peek_en), .peek_off(peek_off),
    .peek_data(peek_data), .peek_valid(peek_valid), .commit(commit), .count(count),
    .empty(empty), .full(full), .lost(lost), .underflow(underflow)
`ifdef UNDO_STACK_PARITY_EN
    , .parity_err(parity_err)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Reference model: the stack is a queue, back = top.
  logic [W-1:0] q[$];
  logic [W-1:0] m_pop_data, m_peek_data;
  bit           m_pop_valid, m_peek_valid, m_peek_known, m_lost, m_underflow;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pop_data   = '0;
    m_peek_data  = '0;
    m_pop_valid  = 1'b0;
    m_peek_valid = 1'b0;
    m_peek_known = 1'b1;
    m_lost       = 1'b0;
    m_underflow  = 1'b0;
  endtask

  task automatic model_step(input bit pu, input logic [W-1:0] pd, input bit po,
                            input bit pe, input int off, input bit cm);
    if (pe) begin
      m_peek_valid = (off < q.size());
      if (m_peek_valid) begin
        m_peek_data  = q[q.size() - 1 - off];
        m_peek_known = 1'b1;
      end else begin
        m_peek_known = 1'b0;
      end
    end else begin
      m_peek_valid = 1'b0;
    end
    if (cm) begin
      q.delete();
      m_lost      = 1'b0;
      m_pop_valid = 1'b0;
      if (pu) q.push_back(pd);
    end else if (po && q.size() > 0) begin
      m_pop_data  = q[q.size() - 1];
      m_pop_valid = 1'b1;
      if (pu) q[q.size() - 1] = pd;
      else void'(q.pop_back());
    end else begin
      m_pop_valid = 1'b0;
      if (po) m_underflow = 1'b1;
      if (pu) begin
        q.push_back(pd);
        if (q.size() > D) begin
          void'(q.pop_front());
          m_lost = 1'b1;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/count"},      32'(count),      32'(q.size()));
    chk({tag, "/empty"},      32'(empty),      32'(q.size() == 0));
    chk({tag, "/full"},       32'(full),       32'(q.size() == D));
    chk({tag, "/lost"},       32'(lost),       32'(m_lost));
    chk({tag, "/underflow"},  32'(underflow),  32'(m_underflow));
    chk({tag, "/pop_valid"},  32'(pop_valid),  32'(m_pop_valid));
    chk({tag, "/pop_data"},   32'(pop_data),   32'(m_pop_data));
    chk({tag, "/peek_valid"}, 32'(peek_valid), 32'(m_peek_valid));
    if (m_peek_known) chk({tag, "/peek_data"}, 32'(peek_data), 32'(m_peek_data));
`ifdef UNDO_STACK_PARITY_EN
    chk({tag, "/parity_err"}, 32'(parity_err), 32'(0));
`endif
  endtask

  // One clock: drive inputs, advance model on the edge, check 1 time unit later.
  task automatic cycle(input string tag, input bit pu, input logic [W-1:0] pd, input bit po,
                       input bit pe, input int off, input bit cm);
    push = pu; push_data = pd; pop = po; peek_en = pe; peek_off = DL'(off); commit = cm;
    @(posedge clk);
    model_step(pu, pd, po, pe, off, cm);
    #1;
    check_all(tag);
  endtask

  // Reset with arbitrary other inputs held high to show reset dominates.
  task automatic do_reset(input string tag, input bit pu, input bit po);
    reset = 1'b1; push = pu; push_data = 16'h5A5A; pop = po; peek_en = 1'b1; peek_off = '0; commit = 1'b0;
    @(posedge clk);
    model_reset();
    #1;
    check_all(tag);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; push = 1'b0; pop = 1'b0; peek_en = 1'b0; commit = 1'b0;
    push_data = '0; peek_off = '0;
    model_reset();

    do_reset("rst0", 1'b0, 1'b0);

    // LIFO order.
    cycle("t1_push", 1'b1, 16'h1111, 1'b0, 1'b0, 0, 1'b0);
    cycle("t1_push", 1'b1, 16'h2222, 1'b0, 1'b0, 0, 1'b0);
    cycle("t1_push", 1'b1, 16'h3333, 1'b0, 1'b0, 0, 1'b0);
    chk("t1_count3", 32'(count), 32'd3);
    cycle("t1_pop", 1'b0, 16'h0, 1'b1, 1'b0, 0, 1'b0);
    chk("t1_pop_a", 32'(pop_data), 32'h3333);
    cycle("t1_pop", 1'b0, 16'h0, 1'b1, 1'b0, 0, 1'b0);
    chk("t1_pop_b", 32'(pop_data), 32'h2222);
    cycle("t1_pop", 1'b0, 16'h0, 1'b1, 1'b0, 0, 1'b0);
    chk("t1_pop_c", 32'(pop_data), 32'h1111);
    chk("t1_empty", 32'(empty), 32'd1);

    // Underflow is sticky, pop_data holds.
    cycle("t2_upop", 1'b0, 16'h0, 1'b1, 1'b0, 0, 1'b0);
    chk("t2_uflag", 32'(underflow), 32'd1);
    chk("t2_hold", 32'(pop_data), 32'h1111);
    cycle("t2_push", 1'b1, 16'hAAAA, 1'b0, 1'b0, 0, 1'b0);
    cycle("t2_pop", 1'b0, 16'h0, 1'b1, 1'b0, 0, 1'b0);
    chk("t2_popdata", 32'(pop_data), 32'hAAAA);
    chk("t2_usticky", 32'(underflow), 32'd1);

    // Wrap-around overwrites the oldest entry.
    do_reset("rst3", 1'b0, 1'b0);
    for (int i = 0; i <= D; i++) cycle("t3_push", 1'b1, W'(i), 1'b0, 1'b0, 0, 1'b0);
    chk("t3_full", 32'(full), 32'd1);
    chk("t3_lost", 32'(lost), 32'd1);
    for (int i = D; i >= 1; i--) begin
      cycle("t3_pop", 1'b0, 16'h0, 1'b1, 1'b0, 0, 1'b0);
      chk("t3_popval", 32'(pop_data), 32'(i));
    end
    cycle("t3_upop", 1'b0, 16'h0, 1'b1, 1'b0, 0, 1'b0);
    chk("t3_uflag", 32'(underflow), 32'd1);

    // Replace-top and peek.
    do_reset("rst4", 1'b0, 1'b0);
    cycle("t4_push", 1'b1, 16'h0005, 1'b0, 1'b0, 0, 1'b0);
    cycle("t4_push", 1'b1, 16'h0007, 1'b0, 1'b0, 0, 1'b0);
    cycle("t4_repl", 1'b1, 16'h0009, 1'b1, 1'b0, 0, 1'b0);
    chk("t4_repl_data", 32'(pop_data), 32'h0007);
    chk("t4_repl_cnt", 32'(count), 32'd2);
    cycle("t4_peek0", 1'b0, 16'h0, 1'b0, 1'b1, 0, 1'b0);
    chk("t4_peek0_d", 32'(peek_data), 32'h0009);
    cycle("t4_peek1", 1'b0, 16'h0, 1'b0, 1'b1, 1, 1'b0);
    chk("t4_peek1_d", 32'(peek_data), 32'h0005);
    cycle("t4_peek2", 1'b0, 16'h0, 1'b0, 1'b1, 2, 1'b0);
    chk("t4_peek2_v", 32'(peek_valid), 32'd0);

    // Commit with same-cycle push.
    do_reset("rst5", 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle("t5_push", 1'b1, W'(16'h0100 + i), 1'b0, 1'b0, 0, 1'b0);
    cycle("t5_commit", 1'b1, 16'hBEEF, 1'b1, 1'b0, 0, 1'b1);
    chk("t5_cnt", 32'(count), 32'd1);
    chk("t5_lost", 32'(lost), 32'd0);
    cycle("t5_pop", 1'b0, 16'h0, 1'b1, 1'b0, 0, 1'b0);
    chk("t5_popdata", 32'(pop_data), 32'hBEEF);
    cycle("t5_upop", 1'b0, 16'h0, 1'b1, 1'b0, 0, 1'b0);
    chk("t5_uflag", 32'(underflow), 32'd1);

    // Reset dominates a push with five entries stacked.
    for (int i = 0; i < 5; i++) cycle("t6_push", 1'b1, W'(16'h0200 + i), 1'b0, 1'b0, 0, 1'b0);
    do_reset("t6_rst", 1'b1, 1'b0);
    chk("t6_cnt", 32'(count), 32'd0);
    cycle("t6_push", 1'b1, 16'h7777, 1'b0, 1'b1, 0, 1'b0);
    cycle("t6_peek", 1'b0, 16'h0, 1'b0, 1'b1, 0, 1'b0);
    chk("t6_peek_d", 32'(peek_data), 32'h7777);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset("rnd_rst", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else begin
        cycle("rnd", 1'($urandom_range(0, 1)), W'($urandom), ($urandom_range(0, 9) < 4),
              1'($urandom_range(0, 1)), int'($urandom_range(0, D - 1)), ($urandom_range(0, 39) == 0));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
